// File: rtl/svp_bit_array_dump.sv
// svp_bit_array_dump: captures a packed sample of SIZE elements, each WIDTH
// bits wide. It then emits them one per valid/ready transfer, in ascending
// index order. Each element is sign- or zero-extended to 64 bits.
//
// Handshake: out_valid stays high for the whole emission. A word moves when
// out_valid=1 and out_ready=1 on a rising clk edge. While out_ready=0 the
// presented word (out_data/out_idx/out_last) does not change. When out_valid=0
// the word outputs read zero.
module svp_bit_array_dump #(
   parameter int WIDTH  = 6,
   parameter int SIZE   = 1,
   parameter int SIGNED = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [SIZE*WIDTH-1:0]   din,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [63:0]             out_data,
   output logic [3:0]              out_idx,
   output logic                    out_last,
   output logic                    busy,
   output logic [31:0]             sample_cnt,
   output logic                    dropped
);

   typedef enum logic {IDLE, EMIT} state_t;

   localparam logic [3:0] LAST_IDX = 4'(SIZE - 1);

   state_t                  state;
   logic [SIZE*WIDTH-1:0]   cap;

   // Pick element k out of a packed sample and widen it to 64 bits.
   function automatic logic [63:0] elem_word(input logic [SIZE*WIDTH-1:0] s,
                                             input logic [3:0] k);
      logic [WIDTH-1:0] e;
      e = WIDTH'(s >> (int'(k) * WIDTH));
      if (SIGNED != 0) elem_word = 64'($signed(e));
      else             elem_word = 64'(e);
   endfunction

   // busy mirrors the FSM state directly
   assign busy = (state == EMIT);

   // Capture / emit FSM with registered word outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cap        <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_idx    <= '0;
         out_last   <= 1'b0;
         sample_cnt <= '0;
         dropped    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_en) begin
                  cap       <= din;
                  state     <= EMIT;
                  out_valid <= 1'b1;
                  out_idx   <= 4'd0;
                  out_data  <= elem_word(din, 4'd0);
                  out_last  <= (LAST_IDX == 4'd0);
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (out_last) begin
                     sample_cnt <= sample_cnt + 32'd1;
                     if (wr_en) begin
                        // back-to-back: the next sample starts with no gap
                        cap      <= din;
                        out_idx  <= 4'd0;
                        out_data <= elem_word(din, 4'd0);
                        out_last <= (LAST_IDX == 4'd0);
                     end else begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_idx   <= 4'd0;
                        out_data  <= '0;
                        out_last  <= 1'b0;
                     end
                  end else begin
                     out_idx  <= out_idx + 4'd1;
                     out_data <= elem_word(cap, out_idx + 4'd1);
                     out_last <= ((out_idx + 4'd1) == LAST_IDX);
                  end
               end
               // a write that cannot be taken now is lost and remembered
               if (wr_en && !(out_ready && out_last)) dropped <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_svp_bit_array_dump.sv
// Testbench for svp_bit_array_dump. It runs two instances:
//   a: WIDTH=8,  SIZE=4, SIGNED=1
//   b: WIDTH=64, SIZE=2, SIGNED=0
// The reference model tracks how many words are still owed for each instance.
// It pushes expected {last, idx, data} words when a sample is accepted. A
// monitor pops and compares words on every falling edge.
module tb_svp_bit_array_dump;

   localparam int WA = 8;
   localparam int SA = 4;
   localparam int WB = 64;
   localparam int SB = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- instance a signals ----------------
   logic             rst_a = 1'b0, wr_en_a = 1'b0, out_ready_a = 1'b0;
   logic [SA*WA-1:0] din_a = '0;
   logic             out_valid_a, out_last_a, busy_a, dropped_a;
   logic [63:0]      out_data_a;
   logic [3:0]       out_idx_a;
   logic [31:0]      sample_cnt_a;

   // ---------------- instance b signals ----------------
   logic             rst_b = 1'b0, wr_en_b = 1'b0, out_ready_b = 1'b0;
   logic [SB*WB-1:0] din_b = '0;
   logic             out_valid_b, out_last_b, busy_b, dropped_b;
   logic [63:0]      out_data_b;
   logic [3:0]       out_idx_b;
   logic [31:0]      sample_cnt_b;

   svp_bit_array_dump #(.WIDTH(WA), .SIZE(SA), .SIGNED(1)) dut_a (
      .clk(clk), .rst(rst_a), .wr_en(wr_en_a), .din(din_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
      .out_idx(out_idx_a), .out_last(out_last_a), .busy(busy_a),
      .sample_cnt(sample_cnt_a), .dropped(dropped_a)
   );

   svp_bit_array_dump #(.WIDTH(WB), .SIZE(SB), .SIGNED(0)) dut_b (
      .clk(clk), .rst(rst_b), .wr_en(wr_en_b), .din(din_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
      .out_idx(out_idx_b), .out_last(out_last_b), .busy(busy_b),
      .sample_cnt(sample_cnt_b), .dropped(dropped_b)
   );

   // ---------------- reference model state ----------------
   logic [68:0] exp_qa[$];
   logic [68:0] exp_qb[$];
   int          rem_a = 0, rem_b = 0;
   logic [31:0] cnt_a = 0, cnt_b = 0;
   logic        drop_a = 1'b0, drop_b = 1'b0;

   // 8-bit two's complement element widened to 64 bits
   function automatic logic [63:0] ref_a(input logic [SA*WA-1:0] d, input int k);
      int v;
      v = int'((d >> (8 * k)) & 32'hFF);
      if (v >= 128) v = v - 256;
      return 64'(longint'(v));
   endfunction

   // 64-bit element returned unchanged
   function automatic logic [63:0] ref_b(input logic [SB*WB-1:0] d, input int k);
      logic [SB*WB-1:0] s;
      s = d >> (64 * k);
      return s[63:0];
   endfunction

   task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------- drivers with model update ----------------
   task automatic step_a(input logic w, input logic [SA*WA-1:0] d, input logic r);
      bit xfer, lastx, acc;
      wr_en_a = w; din_a = d; out_ready_a = r;
      @(posedge clk);
      xfer  = (rem_a > 0) && r;
      lastx = xfer && (rem_a == 1);
      acc   = w && ((rem_a == 0) || lastx);
      if (w && !acc) drop_a = 1'b1;
      if (xfer) rem_a--;
      if (lastx) cnt_a++;
      if (acc) begin
         for (int k = 0; k < SA; k++)
            exp_qa.push_back({(k == SA - 1), 4'(k), ref_a(d, k)});
         rem_a = SA;
      end
      #1;
   endtask

   task automatic step_b(input logic w, input logic [SB*WB-1:0] d, input logic r);
      bit xfer, lastx, acc;
      wr_en_b = w; din_b = d; out_ready_b = r;
      @(posedge clk);
      xfer  = (rem_b > 0) && r;
      lastx = xfer && (rem_b == 1);
      acc   = w && ((rem_b == 0) || lastx);
      if (w && !acc) drop_b = 1'b1;
      if (xfer) rem_b--;
      if (lastx) cnt_b++;
      if (acc) begin
         for (int k = 0; k < SB; k++)
            exp_qb.push_back({(k == SB - 1), 4'(k), ref_b(d, k)});
         rem_b = SB;
      end
      #1;
   endtask

   task automatic reset_a();
      rst_a = 1'b1; wr_en_a = 1'b1; out_ready_a = 1'b0;
      exp_qa.delete(); rem_a = 0; cnt_a = 0; drop_a = 1'b0;
      #1;
      check("rst_now_a", {out_valid_a, out_last_a, out_idx_a, out_data_a, busy_a, dropped_a}, '0);
      check("rst_cnt_a", sample_cnt_a, '0);
      repeat (2) @(posedge clk);
      #1 rst_a = 1'b0; wr_en_a = 1'b0;
   endtask

   task automatic reset_b();
      rst_b = 1'b1; wr_en_b = 1'b1; out_ready_b = 1'b0;
      exp_qb.delete(); rem_b = 0; cnt_b = 0; drop_b = 1'b0;
      #1;
      check("rst_now_b", {out_valid_b, out_last_b, out_idx_b, out_data_b, busy_b, dropped_b}, '0);
      check("rst_cnt_b", sample_cnt_b, '0);
      repeat (2) @(posedge clk);
      #1 rst_b = 1'b0; wr_en_b = 1'b0;
   endtask

   task automatic drain_a();
      for (int i = 0; i < 100 && rem_a > 0; i++) step_a(1'b0, $urandom, 1'b1);
      check("drain_a", rem_a, 0);
   endtask

   task automatic drain_b();
      for (int i = 0; i < 100 && rem_b > 0; i++) step_b(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
      check("drain_b", rem_b, 0);
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      check("valid_a", out_valid_a, (rem_a > 0));
      check("busy_a", busy_a, (rem_a > 0));
      check("cnt_a", sample_cnt_a, cnt_a);
      check("dropped_a", dropped_a, drop_a);
      if (out_valid_a) begin
         if (exp_qa.size() == 0) begin
            total++; bad++;
            $display("FAIL word_a actual=%h expected=none", {out_last_a, out_idx_a, out_data_a});
         end else begin
            check("word_a", {out_last_a, out_idx_a, out_data_a}, exp_qa[0]);
            if (out_ready_a) void'(exp_qa.pop_front());
         end
      end else begin
         check("idle_zero_a", {out_last_a, out_idx_a, out_data_a}, '0);
      end
   end

   always @(negedge clk) begin
      check("valid_b", out_valid_b, (rem_b > 0));
      check("busy_b", busy_b, (rem_b > 0));
      check("cnt_b", sample_cnt_b, cnt_b);
      check("dropped_b", dropped_b, drop_b);
      if (out_valid_b) begin
         if (exp_qb.size() == 0) begin
            total++; bad++;
            $display("FAIL word_b actual=%h expected=none", {out_last_b, out_idx_b, out_data_b});
         end else begin
            check("word_b", {out_last_b, out_idx_b, out_data_b}, exp_qb[0]);
            if (out_ready_b) void'(exp_qb.pop_front());
         end
      end else begin
         check("idle_zero_b", {out_last_b, out_idx_b, out_data_b}, '0);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      #2;
      reset_a();
      reset_b();

      // stalled first word then drain, din changes while emitting
      step_a(1'b1, 32'hFF7F0180, 1'b0);
      check("first_word_a", out_data_a, 64'hFFFFFFFFFFFFFF80);
      repeat (3) step_a(1'b0, $urandom, 1'b0);
      check("held_word_a", {out_idx_a, out_data_a}, {4'd0, 64'hFFFFFFFFFFFFFF80});
      repeat (4) step_a(1'b0, $urandom, 1'b1);
      check("one_sample_a", sample_cnt_a, 32'd1);

      // write at idx1 is dropped; write on the last transfer is taken at once
      step_a(1'b1, $urandom, 1'b1);
      step_a(1'b0, $urandom, 1'b1);
      step_a(1'b1, $urandom, 1'b1);
      step_a(1'b0, $urandom, 1'b1);
      step_a(1'b1, 32'h00000102, 1'b1);
      check("drop_set_a", dropped_a, 1'b1);
      check("b2b_a", {busy_a, out_idx_a, out_data_a}, {1'b1, 4'd0, 64'h2});
      drain_a();

      // reset in the middle of a sample abandons it
      reset_a();
      step_a(1'b1, $urandom, 1'b1);
      step_a(1'b0, $urandom, 1'b1);
      step_a(1'b0, $urandom, 1'b1);
      check("mid_idx_a", out_idx_a, 4'd2);
      reset_a();
      step_a(1'b1, $urandom, 1'b1);
      check("restart_idx_a", {out_valid_a, out_idx_a}, {1'b1, 4'd0});
      drain_a();

      // random traffic
      for (int i = 0; i < 400; i++)
         step_a(($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 3) != 0));
      drain_a();

      // 64-bit elements pass unchanged
      step_b(1'b1, {64'h1, 64'h8000000000000000}, 1'b1);
      check("wide_word0_b", out_data_b, 64'h8000000000000000);
      step_b(1'b0, '0, 1'b1);
      check("wide_word1_b", {out_last_b, out_data_b}, {1'b1, 64'h1});
      drain_b();

      // 200 samples back to back
      reset_b();
      for (int i = 0; i < 200; i++) begin
         step_b(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
         step_b(1'b0, '0, 1'b1);
      end
      drain_b();
      check("b2b_count_b", sample_cnt_b, 32'd200);
      check("b2b_nodrop_b", dropped_b, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
